// File: rtl/fifo_pkg.sv
// Shared width helpers and the status payload for fifo_flex.
package fifo_pkg;

  // Pointer width for a DEPTH-entry buffer.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Occupancy width: must represent 0..DEPTH inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_flex_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one read port that is
// registered by default and asynchronous when FIFO_FWFT_EN is defined.
module fifo_flex_mem
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array is intentionally not reset; occupancy tracking makes stale data invisible.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wdata;
    end
  end

`ifdef FIFO_FWFT_EN
  logic unused_rd;
  assign unused_rd = ^{rst, rd_en};
  assign rdata     = mem[rd_addr];
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[rd_addr];
    end
  end
`endif

endmodule

// File: rtl/fifo_flex.sv
// Single-clock FIFO with arbitrary depth, thresholds, occupancy and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads (zero read latency).
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2,
  localparam int unsigned PTR_W    = ptr_w(DEPTH),
  localparam int unsigned CNT_W    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  input  logic             flush,
  output logic             full_flag,
  output logic             empty_flag,
  output logic             almost_full_flag,
  output logic             almost_empty_flag,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  if (DEPTH < 2) begin : g_depth_chk
    $fatal(1, "fifo_flex: DEPTH must be at least 2");
  end
  if (AE_THRESH >= AF_THRESH) begin : g_thresh_chk
    $fatal(1, "fifo_flex: AE_THRESH must be below AF_THRESH");
  end

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [PTR_W-1:0] wptr, wptr_next;
  logic [PTR_W-1:0] rptr, rptr_next;
  logic [CNT_W-1:0] count_q, count_next;
  fifo_status_t     status, status_next;
  logic             wr_acc, rd_acc;

  // Acceptance, pointer/count update and error tracking; flush wins over everything.
  always_comb begin
    rd_acc      = rd_en & ~status.empty & ~flush;
    wr_acc      = wr_en & (~status.full | rd_acc) & ~flush;
    wptr_next   = wptr;
    rptr_next   = rptr;
    count_next  = count_q;
    status_next = status;

    if (flush) begin
      wptr_next             = '0;
      rptr_next             = '0;
      count_next            = '0;
      status_next.overflow  = 1'b0;
      status_next.underflow = 1'b0;
    end else begin
      if (wr_acc) begin
        wptr_next = ptr_inc(wptr);
      end
      if (rd_acc) begin
        rptr_next = ptr_inc(rptr);
      end
      count_next = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
      if (wr_en & ~wr_acc) begin
        status_next.overflow = 1'b1;
      end
      if (rd_en & status.empty) begin
        status_next.underflow = 1'b1;
      end
    end

    // Level flags registered from the next count so they track the count register.
    status_next.full         = (count_next == CNT_W'(DEPTH));
    status_next.empty        = (count_next == '0);
    status_next.almost_full  = (32'(count_next) >= AF_THRESH);
    status_next.almost_empty = (32'(count_next) <= AE_THRESH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr                <= '0;
      rptr                <= '0;
      count_q             <= '0;
      status.full         <= 1'b0;
      status.empty        <= 1'b1;
      status.almost_full  <= 1'b0;
      status.almost_empty <= 1'b1;
      status.overflow     <= 1'b0;
      status.underflow    <= 1'b0;
    end else begin
      wptr    <= wptr_next;
      rptr    <= rptr_next;
      count_q <= count_next;
      status  <= status_next;
    end
  end

  fifo_flex_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wptr),
    .wdata   (wdata),
    .rd_en   (rd_acc),
    .rd_addr (rptr),
    .rdata   (rdata)
  );

`ifdef FIFO_FWFT_EN
  assign rvalid = ~status.empty;
`else
  logic rvalid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
    end
  end

  assign rvalid = rvalid_q;
`endif

  assign count             = count_q;
  assign full_flag         = status.full;
  assign empty_flag        = status.empty;
  assign almost_full_flag  = status.almost_full;
  assign almost_empty_flag = status.almost_empty;
  assign overflow          = status.overflow;
  assign underflow         = status.underflow;

endmodule

// File: tb/tb_fifo_flex.sv
// Directed bench for fifo_flex: a DEPTH=8 instance for the main sequence and a
// DEPTH=5 instance for non-power-of-2 wrap; aware of FIFO_FWFT_EN read timing.
module tb_fifo_flex;

  logic clk = 1'b0;
  logic rst;

  logic        wr_en8, rd_en8, flush8;
  logic [31:0] wdata8, rdata8;
  logic        rvalid8, full8, empty8, af8, ae8, ov8, un8;
  logic [3:0]  count8;

  logic        wr_en5, rd_en5, flush5;
  logic [31:0] wdata5, rdata5;
  logic        rvalid5, full5, empty5, af5, ae5, ov5, un5;
  logic [2:0]  count5;

  int tests  = 0;
  int failed = 0;

  logic [31:0] wdat [8] = '{32'hD4F40099, 32'h281B86C4, 32'h5E3A91F2, 32'h0C7D2B68,
                            32'hF19A4E37, 32'h6B08D5A1, 32'h93C2167E, 32'h3A5FE80D};
  logic [31:0] q [$];

  always #5 clk = ~clk;

  fifo_flex #(.WIDTH(32), .DEPTH(8)) u8 (
    .clk(clk), .rst(rst), .wr_en(wr_en8), .wdata(wdata8), .rd_en(rd_en8),
    .rdata(rdata8), .rvalid(rvalid8), .flush(flush8), .full_flag(full8),
    .empty_flag(empty8), .almost_full_flag(af8), .almost_empty_flag(ae8),
    .count(count8), .overflow(ov8), .underflow(un8)
  );

  fifo_flex #(.WIDTH(32), .DEPTH(5)) u5 (
    .clk(clk), .rst(rst), .wr_en(wr_en5), .wdata(wdata5), .rd_en(rd_en5),
    .rdata(rdata5), .rvalid(rvalid5), .flush(flush5), .full_flag(full5),
    .empty_flag(empty5), .almost_full_flag(af5), .almost_empty_flag(ae5),
    .count(count5), .overflow(ov5), .underflow(un5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push8(input logic [31:0] d);
    wr_en8 = 1'b1;
    wdata8 = d;
    step();
    wr_en8 = 1'b0;
  endtask

  // Pop one word and check it; FWFT checks the presented head before the pop.
  task automatic pop_chk(input bit sel5, input logic [31:0] exp, input string tag);
`ifdef FIFO_FWFT_EN
    check({tag, " rvalid"}, sel5 ? 32'(rvalid5) : 32'(rvalid8), 32'd1);
    check(tag, sel5 ? rdata5 : rdata8, exp);
`endif
    if (sel5) rd_en5 = 1'b1;
    else      rd_en8 = 1'b1;
    step();
    rd_en5 = 1'b0;
    rd_en8 = 1'b0;
`ifndef FIFO_FWFT_EN
    check({tag, " rvalid"}, sel5 ? 32'(rvalid5) : 32'(rvalid8), 32'd1);
    check(tag, sel5 ? rdata5 : rdata8, exp);
`endif
  endtask

  initial begin
    rst = 1'b0;
    wr_en8 = 1'b0; rd_en8 = 1'b0; flush8 = 1'b0; wdata8 = '0;
    wr_en5 = 1'b0; rd_en5 = 1'b0; flush5 = 1'b0; wdata5 = '0;
    step();
    step();

    // Reset state
    check("rst count", 32'(count8), 32'd0);
    check("rst empty", 32'(empty8), 32'd1);
    check("rst ae", 32'(ae8), 32'd1);
    check("rst full", 32'(full8), 32'd0);
    check("rst af", 32'(af8), 32'd0);
    check("rst ov", 32'(ov8), 32'd0);
    check("rst un", 32'(un8), 32'd0);
    check("rst rvalid", 32'(rvalid8), 32'd0);
`ifndef FIFO_FWFT_EN
    check("rst rdata", rdata8, 32'd0);
`endif
    rst = 1'b1;
    step();

    // 1: fill to DEPTH, watching thresholds (AF=6, AE=2)
    for (int i = 0; i < 8; i++) begin
      push8(wdat[i]);
      check("t1 count", 32'(count8), 32'(i + 1));
      check("t1 af", 32'(af8), (i + 1 >= 6) ? 32'd1 : 32'd0);
      check("t1 full", 32'(full8), (i + 1 == 8) ? 32'd1 : 32'd0);
      check("t1 ae", 32'(ae8), (i + 1 <= 2) ? 32'd1 : 32'd0);
      check("t1 empty", 32'(empty8), 32'd0);
      check("t1 ov", 32'(ov8), 32'd0);
    end

    // 2: write while full is dropped, then drain in order
    push8(32'hBABABABA);
    check("t2 ov", 32'(ov8), 32'd1);
    check("t2 count", 32'(count8), 32'd8);
    for (int i = 0; i < 8; i++) pop_chk(1'b0, wdat[i], "t2 rd");
    check("t2 empty", 32'(empty8), 32'd1);
    check("t2 count0", 32'(count8), 32'd0);
    check("t2 un", 32'(un8), 32'd0);

    // 3: read when empty, then simultaneous read+write when empty
    rd_en8 = 1'b1;
    step();
    rd_en8 = 1'b0;
    check("t3 un", 32'(un8), 32'd1);
    check("t3 rvalid", 32'(rvalid8), 32'd0);
    check("t3 count", 32'(count8), 32'd0);
    rd_en8 = 1'b1; wr_en8 = 1'b1; wdata8 = 32'h76543210;
    step();
    rd_en8 = 1'b0; wr_en8 = 1'b0;
    check("t3 count1", 32'(count8), 32'd1);
    check("t3 un sticky", 32'(un8), 32'd1);
`ifndef FIFO_FWFT_EN
    check("t3 rd rejected", 32'(rvalid8), 32'd0);
`endif
    pop_chk(1'b0, 32'h76543210, "t3 rd");

    // 4: DEPTH=5, 2-write/1-read pattern across pointer wrap
    for (int i = 0; i < 12; i++) begin
      if (q.size() == 5) pop_chk(1'b1, q.pop_front(), "t4 rd");
      wr_en5 = 1'b1;
      wdata5 = 32'hA0000000 + 32'(i);
      step();
      wr_en5 = 1'b0;
      q.push_back(32'hA0000000 + 32'(i));
      check("t4 count", 32'(count5), 32'(q.size()));
      if (i % 2 == 1) pop_chk(1'b1, q.pop_front(), "t4 rd");
    end
    while (q.size() > 0) pop_chk(1'b1, q.pop_front(), "t4 drain");
    check("t4 empty", 32'(empty5), 32'd1);
    check("t4 ae", 32'(ae5), 32'd1);
    check("t4 af", 32'(af5), 32'd0);
    check("t4 full", 32'(full5), 32'd0);
    check("t4 ov", 32'(ov5), 32'd0);
    check("t4 un", 32'(un5), 32'd0);

    // 5: clear errors, fill, then read+write while full
    flush8 = 1'b1;
    step();
    flush8 = 1'b0;
    check("t5 flush ov", 32'(ov8), 32'd0);
    check("t5 flush un", 32'(un8), 32'd0);
    for (int i = 0; i < 8; i++) push8(wdat[i]);
    check("t5 full", 32'(full8), 32'd1);
`ifdef FIFO_FWFT_EN
    check("t5 head", rdata8, wdat[0]);
`endif
    rd_en8 = 1'b1; wr_en8 = 1'b1; wdata8 = 32'h89ABCDEF;
    step();
    rd_en8 = 1'b0; wr_en8 = 1'b0;
    check("t5 count", 32'(count8), 32'd8);
    check("t5 ov", 32'(ov8), 32'd0);
`ifndef FIFO_FWFT_EN
    check("t5 rd0", rdata8, wdat[0]);
`endif
    for (int i = 1; i < 8; i++) pop_chk(1'b0, wdat[i], "t5 rd");
    pop_chk(1'b0, 32'h89ABCDEF, "t5 rd8");
    check("t5 empty", 32'(empty8), 32'd1);

    // 6: flush with 3 stored and overflow set, then async reset mid-burst
    for (int i = 0; i < 8; i++) push8(wdat[i]);
    push8(32'hBABABABA);
    for (int i = 0; i < 5; i++) pop_chk(1'b0, wdat[i], "t6 rd");
    check("t6 count3", 32'(count8), 32'd3);
    check("t6 ov set", 32'(ov8), 32'd1);
    flush8 = 1'b1; wr_en8 = 1'b1; wdata8 = 32'hCAFEF00D;
    step();
    flush8 = 1'b0; wr_en8 = 1'b0;
    check("t6 count", 32'(count8), 32'd0);
    check("t6 empty", 32'(empty8), 32'd1);
    check("t6 ov", 32'(ov8), 32'd0);
`ifndef FIFO_FWFT_EN
    check("t6 rvalid", 32'(rvalid8), 32'd0);
    check("t6 rdata held", rdata8, wdat[4]);
`endif
    push8(32'h13579BDF);
    check("t6 empty off", 32'(empty8), 32'd0);
    check("t6 count1", 32'(count8), 32'd1);
`ifdef FIFO_FWFT_EN
    check("t6 fwft head", rdata8, 32'h13579BDF);
    check("t6 fwft rvalid", 32'(rvalid8), 32'd1);
`endif
    wr_en8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wdata8 = 32'h00000100 + 32'(i);
      step();
    end
    check("t6 burst count", 32'(count8), 32'd8);
    check("t6 burst ov", 32'(ov8), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t6 arst count", 32'(count8), 32'd0);
    check("t6 arst empty", 32'(empty8), 32'd1);
    check("t6 arst ae", 32'(ae8), 32'd1);
    check("t6 arst full", 32'(full8), 32'd0);
    check("t6 arst af", 32'(af8), 32'd0);
    check("t6 arst ov", 32'(ov8), 32'd0);
    check("t6 arst un", 32'(un8), 32'd0);
    check("t6 arst rvalid", 32'(rvalid8), 32'd0);
`ifndef FIFO_FWFT_EN
    check("t6 arst rdata", rdata8, 32'd0);
`endif
    wr_en8 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
